// File: rtl/rr_merge_2_1.sv
// Two-input round-robin stream merge with a registered output stage and source tag.
// Optional per-channel accept counters are enabled by defining RR_MERGE_STATS_EN.
module rr_merge_2_1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
`ifdef RR_MERGE_STATS_EN
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1,
`endif
    input  logic             out_ready
);

    logic prio;
    logic space;
    logic grant;
    logic accept;

    always_comb begin
        space  = !out_valid || out_ready;
        grant  = (in0_valid && in1_valid) ? prio : in1_valid;
        // Readys are held low during reset, when the cleared register would otherwise report space.
        accept    = space && (in0_valid || in1_valid) && !rst;
        in0_ready = accept && !grant;
        in1_ready = accept && grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            prio      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= grant ? in1_data : in0_data;
            out_src   <= grant;
            prio      <= ~grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RR_MERGE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (in0_valid && in0_ready) cnt0 <= cnt0 + 16'd1;
            if (in1_valid && in1_ready) cnt1 <= cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_merge_2_1.sv
// Directed self-checking bench for rr_merge_2_1: reset, throughput, contention,
// backpressure, mid-operation reset and (with RR_MERGE_STATS_EN) counter wrap.
module tb_rr_merge_2_1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in0_valid = 1'b0;
    logic [7:0] in0_data = '0;
    logic       in0_ready;
    logic       in1_valid = 1'b0;
    logic [7:0] in1_data = '0;
    logic       in1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_src;
    logic       out_ready = 1'b0;
`ifdef RR_MERGE_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_merge_2_1 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
`ifdef RR_MERGE_STATS_EN
        .cnt0      (cnt0),
        .cnt1      (cnt1),
`endif
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 16'(out_valid), 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    initial begin
        // Reset then idle; valids high during reset to show readys are forced low.
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("reset_out_valid", 16'(out_valid), 16'h0);
        check("reset_out_data", 16'(out_data), 16'h00);
        check("reset_out_src", 16'(out_src), 16'h0);
        check("reset_in0_ready", 16'(in0_ready), 16'h0);
        check("reset_in1_ready", 16'(in1_ready), 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold_valid", 16'(out_valid), 16'h0);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        rst = 1'b0;
        step();
        check("idle_out_valid", 16'(out_valid), 16'h0);

        // Single channel, full throughput.
        in0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in0_data = 8'h11 + 8'(i);
            #1;
            check("single_in0_ready", 16'(in0_ready), 16'h1);
            step();
            check("single_out_valid", 16'(out_valid), 16'h1);
            check("single_out_data", 16'(out_data), 16'(8'h11 + 8'(i)));
            check("single_out_src", 16'(out_src), 16'h0);
        end
        in0_valid = 1'b0;
        step();
        check("drain_out_valid", 16'(out_valid), 16'h0);
        check("drain_data_hold", 16'(out_data), 16'h13);

        // Contention from reset priority: 0,1,0,1.
        pulse_reset();
        in0_valid = 1'b1;
        in0_data  = 8'hA0;
        in1_valid = 1'b1;
        in1_data  = 8'hB0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_in0_ready", 16'(in0_ready), 16'((i % 2) == 0));
            check("cont_in1_ready", 16'(in1_ready), 16'((i % 2) == 1));
            step();
            check("cont_out_src", 16'(out_src), 16'((i % 2) == 1));
            check("cont_out_data", 16'(out_data), ((i % 2) == 0) ? 16'hA0 : 16'hB0);
        end

        // Backpressure: hold 0x5C for 3 stalled cycles.
        in1_valid = 1'b0;
        in0_data  = 8'h5C;
        step();
        check("bp_load_data", 16'(out_data), 16'h5C);
        out_ready = 1'b0;
        in0_data  = 8'h5D;
        in1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in0_ready", 16'(in0_ready), 16'h0);
            check("bp_in1_ready", 16'(in1_ready), 16'h0);
            step();
            check("bp_out_valid", 16'(out_valid), 16'h1);
            check("bp_out_data", 16'(out_data), 16'h5C);
            check("bp_out_src", 16'(out_src), 16'h0);
        end
        // Prio was 1 after the 0x5C grant and must have held through the stall.
        out_ready = 1'b1;
        #1;
        check("bp_release_in1_ready", 16'(in1_ready), 16'h1);
        step();
        check("bp_next_data", 16'(out_data), 16'hB0);
        check("bp_next_src", 16'(out_src), 16'h1);

        // Reset mid-operation: held 0x77 discarded, prio back to 0.
        in1_valid = 1'b0;
        in0_data  = 8'h77;
        step();
        check("mid_load_data", 16'(out_data), 16'h77);
        in0_valid = 1'b0;
        out_ready = 1'b0;
        // Grant to in0 leaves prio=1; reset must clear it.
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 16'(out_valid), 16'h0);
        check("mid_rst_out_data", 16'(out_data), 16'h00);
        #3 rst = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 8'hA0;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mid_first_in0_ready", 16'(in0_ready), 16'h1);
        check("mid_first_in1_ready", 16'(in1_ready), 16'h0);
        step();
        check("mid_first_src", 16'(out_src), 16'h0);
        check("mid_first_data", 16'(out_data), 16'hA0);

`ifdef RR_MERGE_STATS_EN
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        pulse_reset();
        check("cnt_reset0", cnt0, 16'h0000);
        check("cnt_reset1", cnt1, 16'h0000);
        in1_valid = 1'b1;
        out_ready = 1'b1;
        repeat (65535) step();
        check("cnt1_full", cnt1, 16'hFFFF);
        check("cnt0_idle", cnt0, 16'h0000);
        step();
        check("cnt1_wrap", cnt1, 16'h0000);
        check("cnt0_unchanged", cnt0, 16'h0000);
        in1_valid = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
